// File: rtl/display_scan_sequencer.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Drives digit select and active-low anodes with a dark guard at each digit change.
module display_scan_sequencer #(
    parameter int TICK_DIV     = 100000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] blank_mask,
    output logic [2:0] seqSel,
    output logic [7:0] anode,
    output logic       digit_tick,
    output logic       frame_done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST      = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        OFF,
        GUARD,
        DRIVE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      anode_q, anode_d;
    logic            tick_q, tick_d;
    logic            frame_q, frame_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            pre_q   <= '0;
            sel_q   <= 3'd0;
            anode_q <= 8'hFF;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        if (!en) begin
            state_d = OFF;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    pre_d   = '0;
                    state_d = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
                end
                GUARD: begin
                    pre_d = pre_q + 1'b1;
                    if (pre_d == GUARD_END) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (pre_q == LAST) begin
                        pre_d   = '0;
                        sel_d   = sel_q + 3'd1;
                        tick_d  = 1'b1;
                        frame_d = (sel_q == 3'd7);
                        state_d = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                    pre_d   = '0;
                end
            endcase
        end
    end

    // Anode follows the upcoming state and digit so it never lags seqSel.
    always_comb begin
        anode_d = 8'hFF;
        if (state_d == DRIVE && !blank_mask[sel_d]) begin
            anode_d = ~(8'b1 << sel_d);
        end
    end

    assign seqSel     = sel_q;
    assign anode      = anode_q;
    assign digit_tick = tick_q;
    assign frame_done = frame_q;

endmodule
